// File: rtl/icb_acc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | icb_acc_pkg : register map, bit indices and sticky-error type for the       |
// |               ICB accelerator bridge.                      Rev 1.0          |
// +-----------------------------------------------------------------------------+
package icb_acc_pkg;

   localparam logic [7:0] C_ADDR_CTRL     = 8'h00;
   localparam logic [7:0] C_ADDR_STATUS   = 8'h04;
   localparam logic [7:0] C_ADDR_DATA_IN  = 8'h08;
   localparam logic [7:0] C_ADDR_DATA_OUT = 8'h0C;
   localparam logic [7:0] C_ADDR_LEVEL    = 8'h10;

   localparam int C_CTRL_START  = 0;
   localparam int C_CTRL_LUT_EN = 1;
   localparam int C_CTRL_INT_EN = 2;
   localparam int C_CTRL_FLUSH  = 3;

   localparam int C_ST_IN_FULL   = 0;
   localparam int C_ST_IN_EMPTY  = 1;
   localparam int C_ST_OUT_FULL  = 2;
   localparam int C_ST_OUT_EMPTY = 3;
   localparam int C_ST_STICKY_LO = 8;

   // Field order places wr_ovf at STATUS bit 8 and bad_addr at bit 11.
   typedef struct packed {
      logic bad_addr;
      logic res_drop;
      logic rd_unf;
      logic wr_ovf;
   } sticky_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_wc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sync_fifo_wc : word FIFO with a narrow-side pack or unpack stage.           |
// |                Level and full/empty are counted in wide words. Rev 1.0      |
// +-----------------------------------------------------------------------------+
module sync_fifo_wc #(
   parameter int W_WIDTH = 32,
   parameter int R_WIDTH = 16,
   parameter int DEPTH   = 80,
   parameter int CW      = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [W_WIDTH-1:0] wr_data,
   input  logic               rd_en,
   output logic [R_WIDTH-1:0] rd_data,
   output logic               full,
   output logic               empty,
   output logic [CW-1:0]      count
);

   localparam int MW     = (W_WIDTH > R_WIDTH) ? W_WIDTH : R_WIDTH;
   localparam int N_WR   = MW / W_WIDTH;
   localparam int N_RD   = MW / R_WIDTH;
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SELW_W = (N_WR > 1) ? $clog2(N_WR) : 1;
   localparam int SELW_R = (N_RD > 1) ? $clog2(N_RD) : 1;

   logic [MW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [MW-1:0] w_wr_word;
   logic          w_wr_last;
   logic          w_rd_last;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_push;
   logic          w_pop;

   assign full    = (r_count == CW'(DEPTH));
   assign empty   = (r_count == '0);
   assign count   = r_count;

   assign w_rd_acc = rd_en & ~empty;
   assign w_pop    = w_rd_acc & w_rd_last;
   // A slice that would complete a word is refused when no word slot is free.
   assign w_wr_acc = wr_en & (~w_wr_last | ~full | w_pop);
   assign w_push   = w_wr_acc & w_wr_last;

   generate
      if (N_WR > 1) begin : g_pack
         logic [MW-W_WIDTH-1:0] r_pack;
         logic [SELW_W-1:0]     r_wsel;

         assign w_wr_last = (r_wsel == SELW_W'(N_WR - 1));
         assign w_wr_word = {wr_data, r_pack};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_pack <= '0;
               r_wsel <= '0;
            end else if (flush) begin
               r_pack <= '0;
               r_wsel <= '0;
            end else if (w_wr_acc) begin
               r_pack <= w_wr_word[MW-1:W_WIDTH];
               r_wsel <= w_wr_last ? '0 : r_wsel + 1'b1;
            end
         end
      end else begin : g_nopack
         assign w_wr_last = 1'b1;
         assign w_wr_word = wr_data;
      end

      if (N_RD > 1) begin : g_unpack
         logic [SELW_R-1:0] r_rsel;

         assign w_rd_last = (r_rsel == SELW_R'(N_RD - 1));
         assign rd_data   = r_mem[r_rptr][r_rsel*R_WIDTH +: R_WIDTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rsel <= '0;
            end else if (flush) begin
               r_rsel <= '0;
            end else if (w_rd_acc) begin
               r_rsel <= w_rd_last ? '0 : r_rsel + 1'b1;
            end
         end
      end else begin : g_nounpack
         assign w_rd_last = 1'b1;
         assign rd_data   = r_mem[r_rptr];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_mem[r_wptr] <= w_wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/icb_acc_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | icb_acc_bridge : ICB slave register front-end feeding sample/result streams |
// |                  of a streaming accelerator.                  Rev 1.0       |
// +-----------------------------------------------------------------------------+
module icb_acc_bridge
   import icb_acc_pkg::*;
#(
   parameter int DW        = 32,
   parameter int SW        = 16,
   parameter int RW        = 8,
   parameter int IN_DEPTH  = 80,
   parameter int OUT_DEPTH = 80,
   parameter int AW        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          icb_cmd_valid,
   output logic          icb_cmd_ready,
   input  logic [AW-1:0] icb_cmd_addr,
   input  logic          icb_cmd_read,
   input  logic [DW-1:0] icb_cmd_wdata,
   output logic          icb_rsp_valid,
   input  logic          icb_rsp_ready,
   output logic [DW-1:0] icb_rsp_rdata,
   output logic          icb_rsp_err,
   output logic          acc_start,
   output logic          acc_lut_en,
   output logic          samp_valid,
   input  logic          samp_ready,
   output logic [SW-1:0] samp_data,
   input  logic          res_valid,
   output logic          res_ready,
   input  logic [RW-1:0] res_data,
   output logic          irq
);

   localparam int ICW = $clog2(IN_DEPTH + 1);
   localparam int OCW = $clog2(OUT_DEPTH + 1);

   logic           r_run;
   logic           r_start;
   logic           r_lut_en;
   logic           r_int_en;
   sticky_t        r_sticky;
   sticky_t        w_sticky_set;
   logic           r_rsp_valid;
   logic           r_rsp_err;
   logic [DW-1:0]  r_rsp_rdata;

   logic           w_cmd_hs;
   logic           w_rsp_hs;
   logic           w_in_full;
   logic           w_in_empty;
   logic           w_out_full;
   logic           w_out_empty;
   logic [ICW-1:0] w_in_cnt;
   logic [OCW-1:0] w_out_cnt;
   logic [SW-1:0]  w_samp;
   logic [DW-1:0]  w_out_word;
   logic           w_in_push;
   logic           w_out_pop;
   logic           w_ctrl_wr;
   logic           w_flush;
   logic           w_err;
   logic [DW-1:0]  w_rdata;
   logic [31:0]    w_status;
   logic [31:0]    w_level;

   // r_run keeps the bus and result side quiet until the first edge out of reset.
   assign icb_cmd_ready = r_run & ~r_rsp_valid;
   assign w_cmd_hs      = icb_cmd_valid & icb_cmd_ready;
   assign w_rsp_hs      = r_rsp_valid & icb_rsp_ready;

   assign w_status = 32'({r_sticky, 4'b0000, w_out_empty, w_out_full, w_in_empty, w_in_full});
   assign w_level  = {16'(w_out_cnt), 16'(w_in_cnt)};
   assign w_flush  = w_ctrl_wr & icb_cmd_wdata[C_CTRL_FLUSH];

   always_comb begin
      w_rdata      = '0;
      w_err        = 1'b0;
      w_in_push    = 1'b0;
      w_out_pop    = 1'b0;
      w_ctrl_wr    = 1'b0;
      w_sticky_set = '0;
      if (w_cmd_hs) begin
         case (icb_cmd_addr)
            AW'(C_ADDR_CTRL): begin
               if (icb_cmd_read) w_rdata = DW'({r_int_en, r_lut_en, r_start});
               else              w_ctrl_wr = 1'b1;
            end
            AW'(C_ADDR_STATUS): begin
               if (icb_cmd_read) w_rdata = DW'(w_status);
               else              w_sticky_set.bad_addr = 1'b1;
            end
            AW'(C_ADDR_DATA_IN): begin
               if (icb_cmd_read)   w_sticky_set.bad_addr = 1'b1;
               else if (w_in_full) w_sticky_set.wr_ovf = 1'b1;
               else                w_in_push = 1'b1;
            end
            AW'(C_ADDR_DATA_OUT): begin
               if (!icb_cmd_read)    w_sticky_set.bad_addr = 1'b1;
               else if (w_out_empty) w_sticky_set.rd_unf = 1'b1;
               else begin
                  w_out_pop = 1'b1;
                  w_rdata   = w_out_word;
               end
            end
            AW'(C_ADDR_LEVEL): begin
               if (icb_cmd_read) w_rdata = DW'(w_level);
               else              w_sticky_set.bad_addr = 1'b1;
            end
            default: w_sticky_set.bad_addr = 1'b1;
         endcase
         w_err = |w_sticky_set;
      end
      w_sticky_set.res_drop = r_run & res_valid & ~res_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run       <= 1'b0;
         r_start     <= 1'b0;
         r_lut_en    <= 1'b0;
         r_int_en    <= 1'b0;
         r_sticky    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_run    <= 1'b1;
         r_sticky <= (w_flush ? sticky_t'('0) : r_sticky) | w_sticky_set;
         if (w_ctrl_wr) begin
            r_start  <= icb_cmd_wdata[C_CTRL_START];
            r_lut_en <= icb_cmd_wdata[C_CTRL_LUT_EN];
            r_int_en <= icb_cmd_wdata[C_CTRL_INT_EN];
         end
         if (w_cmd_hs) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= w_rdata;
         end else if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign icb_rsp_valid = r_rsp_valid;
   assign icb_rsp_rdata = r_rsp_rdata;
   assign icb_rsp_err   = r_rsp_err;
   assign acc_start     = r_start;
   assign acc_lut_en    = r_lut_en;
   assign samp_valid    = (r_start | r_lut_en) & ~w_in_empty;
   assign samp_data     = samp_valid ? w_samp : '0;
   assign res_ready     = r_run & ~w_out_full;
   assign irq           = r_int_en & ((|r_sticky) | ~w_out_empty);

   sync_fifo_wc #(
      .W_WIDTH (DW),
      .R_WIDTH (SW),
      .DEPTH   (IN_DEPTH),
      .CW      (ICW)
   ) u_in_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (w_flush),
      .wr_en   (w_in_push),
      .wr_data (icb_cmd_wdata),
      .rd_en   (samp_valid & samp_ready),
      .rd_data (w_samp),
      .full    (w_in_full),
      .empty   (w_in_empty),
      .count   (w_in_cnt)
   );

   sync_fifo_wc #(
      .W_WIDTH (RW),
      .R_WIDTH (DW),
      .DEPTH   (OUT_DEPTH),
      .CW      (OCW)
   ) u_out_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (w_flush),
      .wr_en   (res_valid & res_ready),
      .wr_data (res_data),
      .rd_en   (w_out_pop),
      .rd_data (w_out_word),
      .full    (w_out_full),
      .empty   (w_out_empty),
      .count   (w_out_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_icb_acc_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_icb_acc_bridge : scoreboard bench for icb_acc_bridge.       Rev 1.0      |
// +-----------------------------------------------------------------------------+
module tb_icb_acc_bridge;

   localparam int DW = 32;
   localparam int SW = 16;
   localparam int RW = 8;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          icb_cmd_valid = 1'b0;
   logic          icb_cmd_ready;
   logic [AW-1:0] icb_cmd_addr = '0;
   logic          icb_cmd_read = 1'b0;
   logic [DW-1:0] icb_cmd_wdata = '0;
   logic          icb_rsp_valid;
   logic          icb_rsp_ready = 1'b1;
   logic [DW-1:0] icb_rsp_rdata;
   logic          icb_rsp_err;
   logic          acc_start;
   logic          acc_lut_en;
   logic          samp_valid;
   logic          samp_ready = 1'b0;
   logic [SW-1:0] samp_data;
   logic          res_valid = 1'b0;
   logic          res_ready;
   logic [RW-1:0] res_data = '0;
   logic          irq;

   typedef struct {
      string       nm;
      logic [31:0] rd;
      logic        err;
   } rsp_t;

   rsp_t        rsp_q[$];
   logic [15:0] samp_q[$];
   rsp_t        mon_e;
   logic [15:0] mon_s;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   icb_acc_bridge #(
      .DW(DW), .SW(SW), .RW(RW), .IN_DEPTH(80), .OUT_DEPTH(80), .AW(AW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .icb_cmd_valid (icb_cmd_valid),
      .icb_cmd_ready (icb_cmd_ready),
      .icb_cmd_addr  (icb_cmd_addr),
      .icb_cmd_read  (icb_cmd_read),
      .icb_cmd_wdata (icb_cmd_wdata),
      .icb_rsp_valid (icb_rsp_valid),
      .icb_rsp_ready (icb_rsp_ready),
      .icb_rsp_rdata (icb_rsp_rdata),
      .icb_rsp_err   (icb_rsp_err),
      .acc_start     (acc_start),
      .acc_lut_en    (acc_lut_en),
      .samp_valid    (samp_valid),
      .samp_ready    (samp_ready),
      .samp_data     (samp_data),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .irq           (irq)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // Response and sample monitor: pops the scoreboard whenever the DUT hands something over.
   always @(negedge clk) begin
      if (rst_n && icb_rsp_valid && icb_rsp_ready) begin
         if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = rsp_q.pop_front();
            chk({mon_e.nm, ".rdata"}, icb_rsp_rdata, mon_e.rd);
            chk({mon_e.nm, ".err"}, 32'(icb_rsp_err), 32'(mon_e.err));
         end
      end
      if (rst_n && samp_valid && samp_ready) begin
         if (samp_q.size() == 0) begin
            chk("samp_unexpected", 32'(samp_data), 32'hFFFF_FFFF);
         end else begin
            mon_s = samp_q.pop_front();
            chk("samp_data", 32'(samp_data), 32'(mon_s));
         end
      end
   end

   task automatic icb(input string nm, input logic rd, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee);
      rsp_t t;
      int   n;
      t.nm = nm; t.rd = er; t.err = ee;
      rsp_q.push_back(t);
      @(posedge clk); #1;
      icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = a; icb_cmd_wdata = wd;
      @(negedge clk);
      n = 0;
      while (!icb_cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!icb_cmd_ready) begin
         chk({nm, ".cmd_timeout"}, 32'd0, 32'd1);
         @(posedge clk); #1;
         icb_cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      icb_cmd_valid = 1'b0;
      @(negedge clk);
      chk({nm, ".latency"}, 32'(icb_rsp_valid), 32'd1);
      n = 0;
      while (icb_rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (icb_rsp_valid) chk({nm, ".rsp_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic drive_res(input logic [7:0] d);
      @(posedge clk); #1;
      res_valid = 1'b1;
      res_data  = d;
   endtask

   task automatic end_res();
      @(posedge clk); #1;
      res_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.rsp_valid", 32'(icb_rsp_valid), 32'd0);
      chk("rst.samp_valid", 32'(samp_valid), 32'd0);
      chk("rst.res_ready", 32'(res_ready), 32'd0);
      chk("rst.irq_start_lut", {29'd0, irq, acc_start, acc_lut_en}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      icb("status_reset", 1'b1, 8'h04, 32'h0, 32'h0000_000A, 1'b0);
      icb("ctrl_wr_start", 1'b0, 8'h00, 32'h1, 32'h0, 1'b0);
      icb("ctrl_rd", 1'b1, 8'h00, 32'h0, 32'h1, 1'b0);
      chk("acc_start", 32'(acc_start), 32'd1);

      samp_ready = 1'b1;
      samp_q.push_back(16'hAAAA);
      samp_q.push_back(16'hBBBB);
      icb("data_in_wr", 1'b0, 8'h08, 32'hBBBB_AAAA, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      icb("level_drained", 1'b1, 8'h10, 32'h0, 32'h0, 1'b0);
      chk("samp_q_drained", 32'(samp_q.size()), 32'd0);

      drive_res(8'h11); drive_res(8'h22); drive_res(8'h33); drive_res(8'h44);
      end_res();
      icb("data_out_rd", 1'b1, 8'h0C, 32'h0, 32'h4433_2211, 1'b0);
      icb("data_out_unf", 1'b1, 8'h0C, 32'h0, 32'h0, 1'b1);
      icb("status_rd_unf", 1'b1, 8'h04, 32'h0, 32'h0000_020A, 1'b0);

      samp_ready = 1'b0;
      for (int i = 0; i < 80; i++) begin
         icb("fill_in", 1'b0, 8'h08, 32'h1000 + i, 32'h0, 1'b0);
      end
      icb("fill_ovf", 1'b0, 8'h08, 32'hDEAD_BEEF, 32'h0, 1'b1);
      icb("level_full", 1'b1, 8'h10, 32'h0, 32'h0000_0050, 1'b0);
      icb("status_wr_ovf", 1'b1, 8'h04, 32'h0, 32'h0000_0309, 1'b0);

      icb("unmapped_wr", 1'b0, 8'h20, 32'h1, 32'h0, 1'b1);
      icb("wo_read", 1'b1, 8'h08, 32'h0, 32'h0, 1'b1);
      icb("ro_write", 1'b0, 8'h04, 32'hFFFF_FFFF, 32'h0, 1'b1);
      icb("status_bad_addr", 1'b1, 8'h04, 32'h0, 32'h0000_0B09, 1'b0);

      icb("ctrl_int_en", 1'b0, 8'h00, 32'h4, 32'h0, 1'b0);
      chk("irq_sticky", 32'(irq), 32'd1);
      icb("ctrl_flush", 1'b0, 8'h00, 32'hC, 32'h0, 1'b0);
      chk("irq_after_flush", 32'(irq), 32'd0);
      icb("status_flushed", 1'b1, 8'h04, 32'h0, 32'h0000_000A, 1'b0);
      icb("level_flushed", 1'b1, 8'h10, 32'h0, 32'h0, 1'b0);
      icb("ctrl_rd_no_flush_bit", 1'b1, 8'h00, 32'h0, 32'h4, 1'b0);

      for (int k = 0; k < 324; k++) drive_res(8'(k));
      end_res();
      icb("status_out_full", 1'b1, 8'h04, 32'h0, 32'h0000_0406, 1'b0);
      icb("level_out_full", 1'b1, 8'h10, 32'h0, 32'h0050_0000, 1'b0);
      chk("irq_out_data", 32'(irq), 32'd1);
      icb("data_out_first", 1'b1, 8'h0C, 32'h0, 32'h0302_0100, 1'b0);
      icb("level_out_79", 1'b1, 8'h10, 32'h0, 32'h004F_0000, 1'b0);
      icb("ctrl_flush2", 1'b0, 8'h00, 32'h8, 32'h0, 1'b0);
      icb("status_flushed2", 1'b1, 8'h04, 32'h0, 32'h0000_000A, 1'b0);

      icb("ctrl_lut", 1'b0, 8'h00, 32'h2, 32'h0, 1'b0);
      samp_ready = 1'b1;
      samp_q.push_back(16'h0001);
      samp_q.push_back(16'h0002);
      icb("data_in_lut", 1'b0, 8'h08, 32'h0002_0001, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      chk("samp_q_lut_drained", 32'(samp_q.size()), 32'd0);
      chk("acc_lut_en", {30'd0, acc_lut_en, acc_start}, 32'h2);

      icb_rsp_ready = 1'b0;
      @(posedge clk); #1;
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 8'h00;
      @(negedge clk);
      chk("hold.cmd_ready_pre", 32'(icb_cmd_ready), 32'd1);
      @(posedge clk); #1;
      icb_cmd_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold.rsp_valid", 32'(icb_rsp_valid), 32'd1);
         chk("hold.rdata", icb_rsp_rdata, 32'h2);
         chk("hold.err", 32'(icb_rsp_err), 32'd0);
         chk("hold.cmd_ready", 32'(icb_cmd_ready), 32'd0);
      end
      #2 rst_n = 1'b0;
      #1 chk("reset_drops_rsp", 32'(icb_rsp_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      icb_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      icb("status_after_rst", 1'b1, 8'h04, 32'h0, 32'h0000_000A, 1'b0);
      icb("ctrl_after_rst", 1'b1, 8'h00, 32'h0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      chk("scoreboard_empty", 32'(rsp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icb_acc_bridge.md
Name: icb_acc_bridge

Overview:
- Parametrised ICB slave front-end for streaming accelerators; the MEL spectrogram engine is the first client.
- Replaces hard-coded FIFO wiring with a small register map, explicit status/sticky-error registers and valid/ready streams on the accelerator side.
- Input path unpacks ICB words into samples. Output path packs accelerator results into ICB words.

Parameters:
- DW, 32, ICB data width. Must be a multiple of SW and of RW.
- SW, 16, sample width to accelerator.
- RW, 8, result width from accelerator.
- IN_DEPTH, 80, input FIFO depth in DW words.
- OUT_DEPTH, 80, output FIFO depth in DW words.
- AW, 8, byte-address bits decoded.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_rdata  out  DW  read data
- icb_rsp_err  out  1  response error
- acc_start  out  1  CTRL.start level to accelerator
- acc_lut_en  out  1  CTRL.lut_en level (coefficient-load mode)
- samp_valid  out  1  sample valid
- samp_ready  in  1  sample accepted
- samp_data  out  SW  sample
- res_valid  in  1  result valid
- res_ready  out  1  result accepted
- res_data  in  RW  result
- irq  out  1  level interrupt

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFOs empty, CTRL=0, STATUS sticky bits=0. samp_valid=0, res_ready=0 until reset deasserts.
- Command handshake:
  - One outstanding command; icb_cmd_ready = !rsp_pending.
  - On cmd handshake, response is registered and icb_rsp_valid asserts the next cycle (latency 1).
  - rdata/err are held stable until icb_rsp_ready; cmd_ready returns high in the cycle after the rsp handshake.
- Register map (byte address):
  - 0x00 CTRL (RW): bit0 start, bit1 lut_en, bit2 int_en. Writing bit3=1 clears sticky errors and flushes both FIFOs (self-clearing, reads 0).
  - 0x04 STATUS (RO): bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty. Sticky bits: bit8 wr_ovf, bit9 rd_unf, bit10 res_drop, bit11 bad_addr.
  - 0x08 DATA_IN (WO): push one DW word.
  - 0x0C DATA_OUT (RO): pop one packed DW word.
  - 0x10 LEVEL (RO): [15:0] input word count, [31:16] output word count.
- Error responses (icb_rsp_err=1, rdata=0, no state change except the sticky bit):
  - write DATA_IN while in_full → wr_ovf
  - read DATA_OUT while out_empty → rd_unf
  - unmapped address, read of a WO register, or write of an RO register → bad_addr
- Input unpack:
  - Each word yields DW/SW samples, LSB slice first.
  - samp_valid = (CTRL.start | CTRL.lut_en) & samples available.
  - A sample is consumed on samp_valid & samp_ready.
  - The word is popped after its last slice is consumed.
- Output pack:
  - res_ready = !out_full.
  - Results fill a DW word LSB slice first; after DW/RW results the word is pushed.
  - res_valid while res_ready=0 is dropped and sets res_drop. The accelerator is not expected to stall.
- Simultaneous events:
  - Push and pop in the same cycle keep the level unchanged, including when full.
  - Flush wins over a concurrent push or pop.
  - A flush discards a partial pack/unpack word.
- Level counts wrap never; the full/empty flags are derived from the counts.
- irq = int_en & (|sticky | !out_empty).
- Reset mid-transaction drops the pending response; rsp_valid=0 immediately.

Decomposition:
- Package icb_acc_pkg:
  - register offsets as constants
  - CTRL/STATUS bit-index constants
  - a typedef for the sticky-error vector
- One sub-module, sync_fifo_wc: a parametrised width-converting FIFO (W_WIDTH, R_WIDTH, DEPTH, count output, flush). It is instantiated twice: DW→SW and RW→DW.

Test Plan:
- Reset, then read STATUS (0x04) → rdata=0x0000000A (both FIFOs empty), err=0, rsp_valid one cycle after cmd handshake.
- CTRL=0x1, write DATA_IN 0xBBBBAAAA with samp_ready=1 → samp_data 0xAAAA then 0xBBBB on consecutive cycles; LEVEL[15:0] returns to 0.
- Drive res_data 0x11,0x22,0x33,0x44 → read DATA_OUT gives 0x44332211; a second read gives err=1, STATUS bit9=1.
- Fill input with 80 writes while samp_ready=0 → 81st write gets err=1, wr_ovf set, LEVEL[15:0]=80 unchanged.
- Write 0x20 (unmapped) → err=1, bad_addr set. Then CTRL write with bit3 → STATUS=0x0000000A, both levels 0.
- Hold icb_rsp_ready=0 for 5 cycles after a read → rdata/err stable and cmd_ready=0 throughout; assert rst_n=0 mid-wait → rsp_valid drops to 0 the same cycle.
